// File: rtl/core_pkg.sv
// Shared constants and state encoding for the scheduler / token controller pair.
package core_pkg;

  localparam int unsigned NUM_AXONS = 256;
  localparam int unsigned AXON_W    = 8;
  localparam int unsigned TICK_W    = 4;

  typedef enum logic [2:0] {
    TC_IDLE  = 3'd0,
    TC_REQ   = 3'd1,
    TC_WAIT  = 3'd2,
    TC_LATCH = 3'd3,
    TC_SCAN  = 3'd4,
    TC_CLEAR = 3'd5,
    TC_DONE  = 3'd6
  } tc_state_t;

endpackage

// File: rtl/axon_prio_enc.sv
// Lowest-set-bit encoder over the axon spike vector.
module axon_prio_enc #(
  parameter int unsigned NUM_AXONS = 256,
  parameter int unsigned AXON_W    = 8
) (
  input  logic [NUM_AXONS-1:0] vec,
  output logic [AXON_W-1:0]    idx,
  output logic                 any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = int'(NUM_AXONS) - 1; i >= 0; i--) begin
      if (vec[i]) idx = AXON_W'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/token_controller.sv
// Tick-driven reader: fetches the scheduler's spike vector for a tick, streams
// the set axon IDs over valid/ready, then asks the scheduler to clear/advance.
module token_controller #(
  parameter int unsigned NUM_AXONS = core_pkg::NUM_AXONS,
  parameter int unsigned AXON_W    = core_pkg::AXON_W,
  parameter int unsigned TICK_W    = core_pkg::TICK_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  output logic                 read_request,
  input  logic [NUM_AXONS-1:0] current_tick_spikes,
  input  logic [TICK_W-1:0]    current_tick,
  output logic                 clear_request,
  input  logic                 error,
  output logic                 error_ack,
  output logic                 axon_valid,
  output logic [AXON_W-1:0]    axon_id,
  output logic [TICK_W-1:0]    axon_tick,
  input  logic                 axon_ready,
  output logic                 busy,
  output logic                 tick_done,
  output logic                 tick_overrun
);

  import core_pkg::*;

  tc_state_t              state;
  logic [NUM_AXONS-1:0]   spike_buf;
  logic [NUM_AXONS-1:0]   buf_next;
  logic [TICK_W-1:0]      tick_reg;
  logic                   pending;
  logic [AXON_W-1:0]      enc_idx;
  logic                   enc_any;

  // Encoder looks at the buffer as it will be next cycle, so axon_valid/axon_id
  // can be registered and still present the next ID right after a handshake.
  axon_prio_enc #(
    .NUM_AXONS (NUM_AXONS),
    .AXON_W    (AXON_W)
  ) u_enc (
    .vec (buf_next),
    .idx (enc_idx),
    .any (enc_any)
  );

  // Next value of the spike buffer: load on LATCH, drop the accepted bit in SCAN.
  always_comb begin
    buf_next = spike_buf;
    if (state == TC_LATCH) begin
      buf_next = current_tick_spikes;
    end else if (state == TC_SCAN && axon_valid && axon_ready) begin
      buf_next[axon_id] = 1'b0;
    end
  end

  assign axon_tick = tick_reg;

  // Tick sequencer with registered outputs, tick queueing and error acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= TC_IDLE;
      spike_buf     <= '0;
      tick_reg      <= '0;
      pending       <= 1'b0;
      tick_overrun  <= 1'b0;
      read_request  <= 1'b0;
      clear_request <= 1'b0;
      tick_done     <= 1'b0;
      error_ack     <= 1'b0;
      axon_valid    <= 1'b0;
      axon_id       <= '0;
      busy          <= 1'b0;
    end else begin
      read_request  <= 1'b0;
      clear_request <= 1'b0;
      tick_done     <= 1'b0;
      error_ack     <= error;
      spike_buf     <= buf_next;

      // One tick may queue while busy; a second one is dropped and flagged.
      if (state != TC_IDLE && tick) begin
        if (pending) tick_overrun <= 1'b1;
        else         pending      <= 1'b1;
      end

      case (state)
        TC_IDLE: begin
          if (tick || pending) begin
            state        <= TC_REQ;
            read_request <= 1'b1;
            busy         <= 1'b1;
            pending      <= tick && pending;
          end
        end
        TC_REQ:   state <= TC_WAIT;
        TC_WAIT:  state <= TC_LATCH;
        TC_LATCH: begin
          state      <= TC_SCAN;
          tick_reg   <= current_tick;
          axon_valid <= enc_any;
          axon_id    <= enc_idx;
        end
        TC_SCAN: begin
          if (spike_buf == '0) begin
            state         <= TC_CLEAR;
            clear_request <= 1'b1;
          end else begin
            axon_valid <= enc_any;
            axon_id    <= enc_idx;
          end
        end
        TC_CLEAR: begin
          state     <= TC_DONE;
          tick_done <= 1'b1;
        end
        TC_DONE: begin
          state <= TC_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= TC_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
